// File: rtl/mdu_sequencer_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcodes, FSM states
// and opcode decode helpers.
package mdu_sequencer_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_RUN  = 2'b01,
    MDU_FIX  = 2'b10
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input mdu_op_e o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for
// divide. {i_hi,i_lo} is the working accumulator, i_opnd the multiplicand/divisor.
module mdu_step
  import mdu_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_opnd,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  always_comb begin
    w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
    w_shift = {i_hi, i_lo[WIDTH-1]};
    // Borrow out of the WIDTH+1-bit subtract means the divisor did not fit.
    w_diff  = w_shift - {1'b0, i_opnd};
    w_ge    = ~w_diff[WIDTH];
    if (i_div) begin
      o_hi = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      o_lo = {i_lo[WIDTH-2:0], w_ge};
    end else begin
      o_hi = w_sum[WIDTH:1];
      o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; runs on magnitudes
// for WIDTH steps, then applies sign correction and commits in a FIX cycle.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             rd_hi,
  input  logic             rd_lo,
  input  logic             mt_hi,
  input  logic             mt_lo,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_p(input logic [2*WIDTH-1:0] v);
    return ~v + (2*WIDTH)'(1);
  endfunction

  mdu_state_e       r_state;
  mdu_op_e          r_op;
  logic             r_sa, r_sb, r_dz;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc_hi, r_acc_lo, r_opnd, r_a_orig;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_busy, r_done;

  logic             w_sa, w_sb;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic [WIDTH-1:0] w_step_hi, w_step_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quo, w_rem;

  always_comb begin
    w_sa    = op_is_signed(mdu_op_e'(op)) & src_a[WIDTH-1];
    w_sb    = op_is_signed(mdu_op_e'(op)) & src_b[WIDTH-1];
    w_abs_a = w_sa ? neg_w(src_a) : src_a;
    w_abs_b = w_sb ? neg_w(src_b) : src_b;
    w_prod  = (r_sa ^ r_sb) ? neg_p({r_acc_hi, r_acc_lo}) : {r_acc_hi, r_acc_lo};
    w_quo   = (r_sa ^ r_sb) ? neg_w(r_acc_lo) : r_acc_lo;
    w_rem   = r_sa ? neg_w(r_acc_hi) : r_acc_hi;
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .i_div  (op_is_div(r_op)),
    .i_hi   (r_acc_hi),
    .i_lo   (r_acc_lo),
    .i_opnd (r_opnd),
    .o_hi   (w_step_hi),
    .o_lo   (w_step_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= MDU_IDLE;
      r_op     <= MDU_MULT;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_dz     <= 1'b0;
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opnd   <= '0;
      r_a_orig <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        MDU_IDLE: begin
          if (start) begin
            r_op     <= mdu_op_e'(op);
            r_sa     <= w_sa;
            r_sb     <= w_sb;
            r_dz     <= (src_b == '0);
            r_a_orig <= src_a;
            r_cnt    <= '0;
            r_acc_hi <= '0;
            // Divide shifts the dividend out of LO; multiply shifts the multiplier.
            r_acc_lo <= op_is_div(mdu_op_e'(op)) ? w_abs_a : w_abs_b;
            r_opnd   <= op_is_div(mdu_op_e'(op)) ? w_abs_b : w_abs_a;
            r_busy   <= 1'b1;
            r_state  <= MDU_RUN;
          end else begin
            if (mt_hi) r_hi <= src_a;
            if (mt_lo) r_lo <= src_a;
          end
        end
        MDU_RUN: begin
          r_acc_hi <= w_step_hi;
          r_acc_lo <= w_step_lo;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= MDU_FIX;
        end
        MDU_FIX: begin
          if (op_is_div(r_op)) begin
            r_lo <= r_dz ? '1 : w_quo;
            r_hi <= r_dz ? r_a_orig : w_rem;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= MDU_IDLE;
        end
        default: r_state <= MDU_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign result    = rd_hi ? r_hi : r_lo;
  assign stall_req = r_busy & (start | rd_hi | rd_lo | mt_hi | mt_lo);

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized scoreboard bench for mdu_sequencer against an arithmetic reference model.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, rd_hi, rd_lo, mt_hi, mt_lo;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, stall_req, done;
  logic [31:0] result, hi, lo;

  int total = 0;
  int bad   = 0;
  logic [65:0] sb_q[$];
  logic [31:0] exp_hi = 0, exp_lo = 0;

  always #5 clk = ~clk;

  mdu_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .rd_hi(rd_hi), .rd_lo(rd_lo),
    .mt_hi(mt_hi), .mt_lo(mt_lo), .busy(busy), .stall_req(stall_req),
    .done(done), .result(result), .hi(hi), .lo(lo)
  );

  always @(posedge clk) assert (!(rd_hi && rd_lo)) else $error("rd_hi and rd_lo asserted together");

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference: plain integer arithmetic on the architectural operands.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'h0, 32'h80000000};
        else p = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest outstanding op.
  always @(posedge clk) begin
    logic [65:0] e;
    #1;
    if (rst_n && done) begin
      if (sb_q.size() == 0) timeout("done_without_pending_op");
      else begin
        e = sb_q.pop_front();
        chk($sformatf("hilo_op%0d", e[65:64]), {hi, lo}, e[63:0]);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic acc;
    start = 1'b1; op = o; src_a = a; src_b = b;
    n = 0; acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = !busy;
      if (!acc) chk("stall_on_busy_start", 64'(stall_req), 64'd1);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (!acc) timeout("issue_accept");
    else begin
      sb_q.push_back({o, model(o, a, b)});
      {exp_hi, exp_lo} = model(o, a, b);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    chk("busy_cycles", 64'(n), 64'd33);
  endtask

  task automatic do_mt(input logic h, input logic [31:0] v);
    mt_hi = h; mt_lo = !h; src_a = v;
    @(negedge clk);
    chk("mt_no_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    mt_hi = 1'b0; mt_lo = 1'b0;
    if (h) exp_hi = v; else exp_lo = v;
    chk("mt_hi_value", 64'(hi), 64'(exp_hi));
    chk("mt_lo_value", 64'(lo), 64'(exp_lo));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic stalled;
    logic [1:0] ro;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start = 0; op = 0; src_a = 0; src_b = 0;
    rd_hi = 0; rd_lo = 0; mt_hi = 0; mt_lo = 0;
    #12;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    issue(2'b00, 32'h00000007, 32'hFFFFFFFD);
    wait_idle();
    chk("mult_7x-3", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFEB});
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle();
    chk("multu_max", {hi, lo}, {32'hFFFFFFFE, 32'h00000001});
    issue(2'b10, 32'hFFFFFFF9, 32'h00000002);
    wait_idle();
    chk("div_-7/2", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
    issue(2'b11, 32'h80000000, 32'h00000003);
    wait_idle();
    chk("divu_big/3", {hi, lo}, {32'h00000002, 32'h2AAAAAAA});
    issue(2'b11, 32'd100, 32'd0);
    wait_idle();
    chk("divu_by_zero", {hi, lo}, {32'h00000064, 32'hFFFFFFFF});
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();
    chk("div_overflow", {hi, lo}, {32'h00000000, 32'h80000000});

    // MFLO one cycle behind the MULT must wait until busy falls.
    issue(2'b00, 32'd5, 32'd6);
    @(posedge clk); #1;
    rd_lo = 1'b1;
    n = 0; stalled = 1'b1;
    while (stalled && n < 100) begin
      @(negedge clk);
      stalled = stall_req;
      if (stalled) n++;
    end
    chk("mflo_stall_cycles", 64'(n), 64'd32);
    chk("mflo_busy_at_release", 64'(busy), 64'd0);
    chk("mflo_result", 64'(result), 64'h1E);
    @(posedge clk); #1;
    rd_lo = 1'b0;

    // start wins over a simultaneous MTLO.
    mt_lo = 1'b1;
    issue(2'b01, 32'd3, 32'd4);
    mt_lo = 1'b0;
    wait_idle();
    chk("start_beats_mtlo", 64'(lo), 64'd12);

    // Back-to-back: the second start is held by the stall, then runs.
    issue(2'b00, 32'd1000, 32'hFFFFFF00);
    issue(2'b11, 32'd1000001, 32'd7);
    wait_idle();
    chk("b2b_second", {hi, lo}, {32'd1000001 % 32'd7, 32'd1000001 / 32'd7});
    @(posedge clk); #1;
    chk("b2b_queue_drained", 64'(sb_q.size()), 64'd0);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      issue(ro, ra, rb);
      wait_idle();
      if ($urandom_range(0, 3) == 0) do_mt(1'($urandom_range(0, 1)), $urandom);
    end

    // Asynchronous reset in the middle of a divide.
    do_mt(1'b1, 32'hDEADBEEF);
    issue(2'b10, 32'hFFFFFF9C, 32'd7);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    sb_q.delete();
    exp_hi = 0; exp_lo = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_mt(1'b0, 32'h00001234);
    chk("after_abort_lo", 64'(lo), 64'h1234);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative multiply/divide controller for the EX stage of the 5-stage pipeline.
- Owns the architectural HI/LO registers and executes MULT/MULTU/DIV/DIVU as a multi-cycle radix-2 operation.
- Serves MFHI/MFLO/MTHI/MTLO.
- Raises a stall request to Hazard_Unit whenever the pipeline needs HI/LO, or the unit itself, while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  EX-stage MULT/MULTU/DIV/DIVU valid; already qualified by FlushE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  in  WIDTH  forwarded SrcAE (multiplicand/dividend; MTHI/MTLO data).
- src_b  in  WIDTH  forwarded WriteData_E (multiplier/divisor).
- rd_hi  in  1  MFHI in EX.
- rd_lo  in  1  MFLO in EX.
- mt_hi  in  1  MTHI in EX.
- mt_lo  in  1  MTLO in EX.
- busy  out  1  operation in flight.
- stall_req  out  1  to Hazard_Unit; stalls F/D and freezes EX.
- done  out  1  one-cycle pulse after HI/LO update.
- result  out  WIDTH  rd_hi ? hi : lo (combinational).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy, done = 0; hi, lo, all working registers = 0.
  - Reset mid-operation aborts it with no HI/LO update.
- States: IDLE, RUN, FIX.
- IDLE:
  - If start is high on edge T: latch op, sign flags, |src_a| and |src_b|. Abs is taken for signed ops only; unsigned ops pass operands through.
  - Clear the count, load the accumulator, go to RUN.
  - busy goes high after T.
- RUN: one step per edge for exactly WIDTH edges, then go to FIX.
  - Multiply: shift-add on a 2*WIDTH-bit product register.
  - Divide: restoring shift-subtract; the WIDTH+1-bit remainder compare decides each quotient bit.
- FIX: a single edge, T+WIDTH+1.
  - Apply sign correction and write HI/LO; go to IDLE; busy drops.
  - done is high for the following cycle.
  - Total busy = WIDTH+1 cycles (33 at default).
- Sign rules:
  - MULT: product negated (2*WIDTH two's complement) if sign_a^sign_b.
  - DIV: quotient negated if sign_a^sign_b; remainder takes sign_a.
- Results:
  - MULT/MULTU: HI = product[2W-1:W], LO = product[W-1:0].
  - DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero (src_b==0 at start): full latency is kept. FIX forces LO = all ones and HI = original src_a, for signed and unsigned alike.
- Signed overflow (0x80000000 / -1): LO = 0x80000000, HI = 0.
- MTHI/MTLO:
  - When not busy, they write src_a into hi/lo on the edge.
  - If start and mt_* are both high in the same cycle, start wins and the mt_* is ignored.
  - While busy, they are held off by the stall.
- stall_req = busy & (start | rd_hi | rd_lo | mt_hi | mt_lo), combinational.
  - A start while busy is not accepted; it is re-presented after release.
  - Stall releases in the cycle busy falls, so MF reads the new value.
- rd_hi and rd_lo together is illegal; a bench assertion covers it.
- result is meaningful only when stall_req=0.
- Non-MDU instructions in EX during busy are not stalled (independent execution).

Decomposition:
- mips.h gains the op encodings `MDU_MULT, `MDU_MULTU, `MDU_DIV, `MDU_DIVU, plus the state encodings `MDU_IDLE, `MDU_RUN, `MDU_FIX.
- One sub-module, mdu_step: combinational single-iteration shift-add/shift-subtract cell.
- The FSM, counter, sign fixup and HI/LO stay in mdu_sequencer.
- Hazard_Unit gains a stall_req input ORed into StallF/StallD and the EX hold.

Test Plan:
- MULT 7 × -3 (0x00000007, 0xFFFFFFFD) → busy 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB, done pulse once.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 0x80000000/3 → LO=0x2AAAAAAA, HI=0x00000002.
- DIVU 100/0 → LO=0xFFFFFFFF, HI=0x00000064, latency unchanged.
- MULT 5×6 then MFLO on the next cycle → stall_req high for 32 cycles; released in the cycle busy falls with result=0x0000001E.
- Back-to-back starts → the second is stalled, not dropped.
- DIV in flight, rst_n pulsed low at RUN cycle 10 → busy=0, hi=lo=0 immediately (no clock edge); MTLO 0x1234 next → lo=0x00001234, no stall.
